uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver; pairs with uart_tx on the serial line. Oversamples i_uart_rx with the
//  system clock, detects the start edge, samples each bit at mid-bit, checks parity/stop.
//  Delivers each word on a valid/ready handshake into the system-side consumer.
// PARAMETERS
//  CLK_FRE      50    system clock in MHz
//  DATA_WIDTH   8     data bits per frame (1..15)
//  PARITY_ON    0     1 = frame carries parity bit
//  PARITY_TYPE  0     1 = odd, 0 = even
//  BAUD_RATE    9600  line rate; CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit
// PORTS
//  i_clk_sys     in   1           system clock
//  i_rst_n       in   1           asynchronous reset, active low
//  i_uart_rx     in   1           serial line, idle high
//  o_data_rx     out  DATA_WIDTH  received word, LSB first on line
//  o_data_valid  out  1           o_data_rx/o_*_err valid; held until i_data_ready
//  i_data_ready  in   1           consumer accepts when valid&&ready at clock edge
//  o_parity_err  out  1           qualifies o_data_rx; 0 when PARITY_ON=0
//  o_frame_err   out  1           stop bit sampled 0; qualifies o_data_rx
//  o_overrun     out  1           1-cycle pulse: frame completed while output still full
// BEHAVIOUR
//  Reset: o_data_rx=0, o_data_valid=0, errs=0, o_overrun=0, state IDLE, counters 0.
//  Input registered into rx_q; falling edge = rx_q_d1 & ~rx_q. Idle-line value 1.
//  Baud counter: 0..CYCLE-1 wrap, held 0 in IDLE, cleared on start edge; sample strobe
//   when cnt==CYCLE/2-1 (mid-bit), bit boundary when cnt==CYCLE-1.
//  FSM: IDLE -edge-> START; START: at strobe, rx_q=0 -> DATA, rx_q=1 -> IDLE (glitch,
//   no output); DATA: shift rx_q in at MSB, right-shift, DATA_WIDTH strobes then
//   PARITY (PARITY_ON) else STOP; PARITY: one strobe, err = ^data^bit^PARITY_TYPE -> STOP;
//   STOP: at strobe capture word, frame_err=~rx_q, -> IDLE immediately (half-bit early,
//   so back-to-back frames with 1 stop bit resync on next start edge).
//  Output: load at stop strobe; o_data_valid=1 next cycle. Cleared on valid&&ready.
//  Full (valid=1, no ready) at load: new word dropped, old word/errs kept, o_overrun=1
//   for one cycle. Load and ready same cycle: old word consumed, new word loaded, no overrun.
//  Framing error frame still delivered with o_frame_err=1; FSM does not wait for line high
//   but only a new falling edge restarts (break/low line produces no further frames).
//  Reset mid-frame: everything returns to reset values asynchronously; partial word lost.
//  Bit counter 4 bits; CYCLE must fit 16-bit counter.
// CONFIGURATION
//  UART_RX_SYNC_EN defined: i_uart_rx passes 2-flop synchronizer (reset to 1) before rx_q;
//   adds 2 cycles edge-to-strobe latency, all mid-bit timing relative unchanged.
//  Undefined: single register only (input already synchronous, e.g. loopback from uart_tx).
// STRUCTURE
//  uart_pkg: state encodings (IDLE/START/DATA/PARITY/STOP), CYCLE calc function,
//   shared with uart_tx.
//  Sub-module uart_baud_cnt: enable/clear in, cnt, mid strobe and end strobe out.
//  Top: input sync, edge detect, FSM, shift reg, parity, output holding reg.
// TESTING (CLK_FRE=50, BAUD_RATE=9600, CYCLE=5208 unless stated)
//  1 send 0xA5, 8N1, ready=1 -> o_data_rx=0xA5, valid 1 cycle, errs 0, ~9.5 bit times.
//  2 PARITY_ON=1 even, send 0x01 with parity bit 0 -> o_data_rx=0x01, o_parity_err=1;
//    parity bit 1 -> o_parity_err=0; PARITY_TYPE=1 inverts both results.
//  3 low glitch 1000 clocks on idle line -> no o_data_valid, FSM back in IDLE.
//  4 send 0x3C with stop bit 0 -> o_data_rx=0x3C, o_frame_err=1.
//  5 ready=0, send 0x11 then 0x22 back-to-back -> o_data_rx stays 0x11, o_overrun pulse
//    once; ready=1 -> valid drops; next 0x33 received cleanly.
//  6 assert i_rst_n=0 during data bit 4 of 0x55 -> outputs reset; next 0x66 received OK.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period calculation,
// used by both the receiver and its uart_tx counterpart.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // System clocks per bit; clk_fre is in MHz.
    function automatic int calc_cycle(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CYCLE-1 while enabled, flags mid-bit and end-of-bit.
module uart_baud_cnt #(
    parameter int CYCLE = 5208
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic        en,
    input  logic        clr,
    output logic [15:0] cnt,
    output logic        mid_stb,
    output logic        end_stb
);

    localparam logic [15:0] CNT_LAST = 16'(CYCLE - 1);
    localparam logic [15:0] CNT_MID  = 16'(CYCLE / 2 - 1);

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (clr || !en || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign mid_stb = en && (cnt == CNT_MID);
    assign end_stb = en && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver with mid-bit sampling, optional parity and a valid/ready output register.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on i_uart_rx.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE     = 50,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int BAUD_RATE   = 9600
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_uart_rx,
    output logic [DATA_WIDTH-1:0] o_data_rx,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_overrun
);

    localparam int         CYCLE    = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
    localparam logic       PAR_ODD  = (PARITY_TYPE != 0);

    uart_state_t           state, state_nxt;
    logic                  rx_in, rx_q, rx_q_d1, fall;
    logic                  mid_stb, end_stb, baud_en, baud_clr;
    logic [15:0]           baud_cnt;
    logic                  shift_en, par_en, load, bit_clr;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_err_q;
    logic                  baud_unused;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_ff;
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) sync_ff <= 2'b11;
        else          sync_ff <= {sync_ff[0], i_uart_rx};
    end
    assign rx_in = sync_ff[1];
`else
    assign rx_in = i_uart_rx;
`endif

    // Idle line is high, so both taps reset to 1 to avoid a false start edge.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_q    <= 1'b1;
            rx_q_d1 <= 1'b1;
        end else begin
            rx_q    <= rx_in;
            rx_q_d1 <= rx_q;
        end
    end
    assign fall = rx_q_d1 & ~rx_q;

    assign baud_en  = (state != ST_IDLE);
    assign baud_clr = (state == ST_IDLE) && fall;

    uart_baud_cnt #(.CYCLE(CYCLE)) u_baud (
        .i_clk_sys (i_clk_sys),
        .i_rst_n   (i_rst_n),
        .en        (baud_en),
        .clr       (baud_clr),
        .cnt       (baud_cnt),
        .mid_stb   (mid_stb),
        .end_stb   (end_stb)
    );
    // Only the mid-bit strobe drives the receiver.
    assign baud_unused = ^{baud_cnt, end_stb};

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fall) state_nxt = ST_START;
            ST_START:  if (mid_stb) state_nxt = rx_q ? ST_IDLE : ST_DATA;
            ST_DATA:   if (mid_stb && bit_cnt == LAST_BIT)
                           state_nxt = (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (mid_stb) state_nxt = ST_STOP;
            // Leave at mid-stop so the next start edge is never missed.
            ST_STOP:   if (mid_stb) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_clr  = (state == ST_START);
        shift_en = (state == ST_DATA)   && mid_stb;
        par_en   = (state == ST_PARITY) && mid_stb;
        load     = (state == ST_STOP)   && mid_stb;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            // LSB arrives first: insert at MSB and shift right.
            if (shift_en) begin
                shift_q <= (shift_q >> 1) | (DATA_WIDTH'(rx_q) << (DATA_WIDTH - 1));
            end
            if (par_en) begin
                par_err_q <= (PARITY_ON != 0) && ((^shift_q) ^ rx_q ^ PAR_ODD);
            end
        end
    end

    // A full holding register drops the new word unless the consumer frees it this cycle.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_rx    <= '0;
            o_data_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= load && o_data_valid && !i_data_ready;
            if (load && (!o_data_valid || i_data_ready)) begin
                o_data_rx    <= shift_q;
                o_data_valid <= 1'b1;
                o_parity_err <= par_err_q;
                o_frame_err  <= ~rx_q;
            end else if (o_data_valid && i_data_ready) begin
                o_data_valid <= 1'b0;
            end
        end
    end

endmodule
